// File: rtl/serial_alu_seq.sv
//==============================================================================
// serial_alu_seq : bit-serial ALU sequencer driving an external 1-bit slice.
// Optional flag outputs with SERIAL_ALU_FLAGS_EN.  Revision: 1.0
//==============================================================================
`default_nettype none

module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [1:0]       slice_op,
  input  logic             slice_s,
  input  logic             slice_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ovf
`endif
);

  localparam int         CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
  localparam logic [1:0] c_op_sub   = 2'b11;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             w_run;

`ifdef SERIAL_ALU_FLAGS_EN
  logic             r_zero;
  logic             r_ovf;
  logic [WIDTH-1:0] w_final;

  // Full result word as it will stand once the MSB from the slice lands.
  assign w_final  = {slice_s, r_result[WIDTH-2:0]};
  assign out_zero = r_zero;
  assign out_ovf  = r_ovf;
`endif

  assign w_run      = (r_state == c_st_run);
  assign in_ready   = (r_state == c_st_idle);
  assign out_valid  = (r_state == c_st_done);
  assign slice_a    = w_run & r_a[r_cnt];
  assign slice_b    = w_run & r_b[r_cnt];
  assign slice_cin  = w_run & r_carry;
  assign slice_op   = r_op;
  assign out_result = r_result;
  assign out_cout   = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_op     <= in_op;
            r_cnt    <= '0;
            r_carry  <= (in_op == c_op_sub);
            r_result <= '0;
            r_state  <= c_st_run;
          end
        end
        c_st_run: begin
          r_result[r_cnt] <= slice_s;
          r_carry         <= slice_cout;
          r_cnt           <= r_cnt + 1'b1;
          if (r_cnt == c_cnt_last) begin
            r_cout  <= slice_cout;
            r_cnt   <= '0;
            r_state <= c_st_done;
`ifdef SERIAL_ALU_FLAGS_EN
            r_zero  <= (w_final == '0);
            // Carry into the MSB is the carry register during the last bit.
            r_ovf   <= r_op[1] & (r_carry ^ slice_cout);
`endif
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
//==============================================================================
// tb_serial_alu_seq : self-checking bench with a 1-bit slice model and a
// word-level arithmetic reference.  Revision: 1.0
//==============================================================================
`default_nettype none

module tb_serial_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic [1:0]       slice_op;
  logic             slice_s;
  logic             slice_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;
`ifdef SERIAL_ALU_FLAGS_EN
  logic             out_zero;
  logic             out_ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_op   (slice_op),
    .slice_s    (slice_s),
    .slice_cout (slice_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cout   (out_cout)
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_ovf    (out_ovf)
`endif
  );

  // External 1-bit slice; logic ops report a&b as carry-out.
  logic [1:0] w_sum;
  always_comb begin
    w_sum      = 2'b00;
    slice_s    = 1'b0;
    slice_cout = 1'b0;
    case (slice_op)
      2'b00: begin slice_s = ~(slice_a | slice_b); slice_cout = slice_a & slice_b; end
      2'b01: begin slice_s = slice_a ^ slice_b;    slice_cout = slice_a & slice_b; end
      2'b10: begin
        w_sum = {1'b0, slice_a} + {1'b0, slice_b} + {1'b0, slice_cin};
        slice_s = w_sum[0]; slice_cout = w_sum[1];
      end
      default: begin
        w_sum = {1'b0, slice_a} + {1'b0, ~slice_b} + {1'b0, slice_cin};
        slice_s = w_sum[0]; slice_cout = w_sum[1];
      end
    endcase
  end

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               hold;
    logic [WIDTH-1:0] res;
    logic             cout;
    logic             zero;
    logic             ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_calc(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                   output logic c, output logic z, output logic v);
    logic [WIDTH:0] s;
    s = '0;
    v = 1'b0;
    case (op)
      2'b00: begin r = ~(a | b); c = a[WIDTH-1] & b[WIDTH-1]; end
      2'b01: begin r = a ^ b;    c = a[WIDTH-1] & b[WIDTH-1]; end
      2'b10: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 1'b1;
        r = s[WIDTH-1:0]; c = s[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
    endcase
    z = (r == '0);
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic             slice_ok;
    logic             stable_ok;
    int               lat;
    logic [WIDTH-1:0] r_snap;
    logic             c_snap;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_op = v.op;
    @(negedge clk);
    slice_ok = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin lat = k + 1; break; end
      if (k < WIDTH)
        slice_ok &= (slice_a === v.a[k]) && (slice_b === v.b[k]) &&
                    (slice_op === v.op) && !in_ready;
      if (k == 0) slice_ok &= (slice_cin === (v.op == 2'b11));
      in_valid = 1'($urandom_range(0, 1));
      in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_op = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
    chk({tag, "_slice_seq"}, 32'(slice_ok), 32'd1);
    chk({tag, "_result"}, 32'(out_result), 32'(v.res));
    chk({tag, "_cout"}, 32'(out_cout), 32'(v.cout));
`ifdef SERIAL_ALU_FLAGS_EN
    chk({tag, "_zero"}, 32'(out_zero), 32'(v.zero));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
`endif
    r_snap = out_result; c_snap = out_cout; stable_ok = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      stable_ok &= out_valid && !in_ready && (out_result === r_snap) && (out_cout === c_snap);
    end
    if (v.hold > 0) chk({tag, "_stall_stable"}, 32'(stable_ok), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready_valid"}, 32'({in_ready, out_valid}), 32'b10);
    chk({tag, "_result"}, 32'(out_result), 32'd0);
    chk({tag, "_cout"}, 32'(out_cout), 32'd0);
    chk({tag, "_slice"}, 32'({slice_a, slice_b, slice_cin, slice_op}), 32'd0);
`ifdef SERIAL_ALU_FLAGS_EN
    chk({tag, "_flags"}, 32'({out_zero, out_ovf}), 32'd0);
`endif
  endtask

  initial begin
    vec_t vecs[8];
    vec_t rv;
    logic no_valid;
    vecs[0] = '{op: 2'b10, a: 8'h3C, b: 8'h05, hold: 0, res: 8'h41, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[1] = '{op: 2'b10, a: 8'hFF, b: 8'h01, hold: 1, res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};
    vecs[2] = '{op: 2'b11, a: 8'h80, b: 8'h01, hold: 0, res: 8'h7F, cout: 1'b1, zero: 1'b0, ovf: 1'b1};
    vecs[3] = '{op: 2'b00, a: 8'hF0, b: 8'h0F, hold: 5, res: 8'h00, cout: 1'b0, zero: 1'b1, ovf: 1'b0};
    vecs[4] = '{op: 2'b01, a: 8'hAA, b: 8'hFF, hold: 5, res: 8'h55, cout: 1'b1, zero: 1'b0, ovf: 1'b0};
    vecs[5] = '{op: 2'b11, a: 8'h05, b: 8'h05, hold: 2, res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};
    vecs[6] = '{op: 2'b10, a: 8'h7F, b: 8'h01, hold: 0, res: 8'h80, cout: 1'b0, zero: 1'b0, ovf: 1'b1};
    vecs[7] = '{op: 2'b11, a: 8'h00, b: 8'h01, hold: 0, res: 8'hFF, cout: 1'b0, zero: 1'b0, ovf: 1'b0};

    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; out_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    #12 rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted away from any clock edge in the middle of RUN.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h3C; in_op = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    no_valid = 1'b1;
    repeat (12) begin
      @(negedge clk);
      no_valid &= !out_valid && in_ready;
    end
    chk("midrun_no_valid", 32'(no_valid), 32'd1);
    rv = '{op: 2'b10, a: 8'h01, b: 8'h01, hold: 0, res: 8'h02, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    run_txn(rv, "after_reset");

    for (int n = 0; n < 40; n++) begin
      rv.op = 2'($urandom);
      rv.a = WIDTH'($urandom);
      rv.b = WIDTH'($urandom);
      rv.hold = $urandom_range(0, 2);
      ref_calc(rv.op, rv.a, rv.b, rv.res, rv.cout, rv.zero, rv.ovf);
      run_txn(rv, $sformatf("rnd%0d_op%0d_%0h_%0h", n, rv.op, rv.a, rv.b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  in_valid  input  1  operand request valid
  in_ready  output  1  block can accept request
  in_a  input  WIDTH  operand A
  in_b  input  WIDTH  operand B
  in_op  input  2  00 NOR, 01 XOR, 10 ADD, 11 SUB
  slice_a  output  1  current A bit to 1-bit ALU slice
  slice_b  output  1  current B bit to slice
  slice_cin  output  1  carry into slice
  slice_op  output  2  op to slice
  slice_s  input  1  slice result bit (combinational from slice_*)
  slice_cout  input  1  slice carry out
  out_valid  output  1  result valid
  out_ready  input  1  consumer accepts result
  out_result  output  WIDTH  result word
  out_cout  output  1  final carry out

Function
REQ-003 SHALL implement FSM IDLE, RUN, DONE.
REQ-004 IDLE: in_ready=1; in_valid=1 latches in_a, in_b, in_op into internal registers, clears bit counter, loads carry register (0 for op 00/01/10, 1 for op 11), moves to RUN.
REQ-005 RUN: in_ready=0; slice_a/slice_b SHALL be bit[cnt] of latched A/B, LSB first; slice_op = latched op; slice_cin = carry register.
REQ-006 Each RUN cycle SHALL shift slice_s into out_result bit position cnt and load slice_cout into carry register; cnt increments.
REQ-007 After cycle with cnt=WIDTH-1, SHALL move to DONE; out_cout = last slice_cout.
REQ-008 Latency: out_valid SHALL assert exactly WIDTH+1 cycles after the in_valid&&in_ready edge.
REQ-009 DONE: out_valid=1, out_result/out_cout stable; on out_valid&&out_ready SHALL return to IDLE next cycle.
REQ-010 No back-to-back overlap: new request only accepted in IDLE; one cycle of in_ready=1 minimum between results.
REQ-011 Carry register SHALL update for NOR/XOR too (slice_cout driven by slice); out_cout for ops 00/01 is don't-care to consumer but SHALL be deterministic register value.
REQ-012 ADD/SUB result SHALL wrap modulo 2^WIDTH; no saturation.
REQ-013 in_a/in_b/in_op changes while not IDLE SHALL have no effect.
REQ-014 Outside RUN, slice_a, slice_b, slice_cin SHALL be 0; slice_op holds last latched op.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, out_result=0, out_cout=0, counter=0, carry=0, latched operands=0.
REQ-016 Reset mid-RUN or in DONE SHALL abandon operation; no out_valid pulse after release.
REQ-017 First request accepted on first rising clk with rst_n high and in_valid=1.

Configuration
REQ-018 Macro SERIAL_ALU_FLAGS_EN defined: add outputs out_zero (1 when out_result==0) and out_ovf (ADD/SUB signed overflow: carry into MSB XOR carry out of MSB), registered with result, valid with out_valid, reset 0.
REQ-019 Macro undefined: out_zero/out_ovf ports and logic absent; all other behaviour identical.

Verification
REQ-020 WIDTH=8, ADD 0x3C+0x05 -> out_result=0x41, out_cout=0, out_valid at cycle 9 after accept.
REQ-021 ADD 0xFF+0x01 -> out_result=0x00, out_cout=1; with SERIAL_ALU_FLAGS_EN out_zero=1, out_ovf=0.
REQ-022 SUB 0x80-0x01 (cin=1 initial) -> out_result=0x7F, out_cout=1; with flags out_ovf=1.
REQ-023 NOR 0xF0,0x0F -> 0x00; XOR 0xAA,0xFF -> 0x55; out_ready held 0 for 5 cycles -> out_valid/result stay stable, in_ready=0.
REQ-024 rst_n pulsed low at RUN cycle 4 -> outputs return to reset values asynchronously, no out_valid; next request 0x01+0x01 -> 0x02.
